pmem_write_buffer: RTL and testbench

//  Write-back buffer between the cache's physical-memory port and physical memory.

---
 rtl/pmem_write_buffer.sv | 190 +++++++++++++++++++
 tb/tb_pmem_write_buffer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_write_buffer.sv
// Write-back buffer between the cache's pmem port and physical memory.
// Holds evicted dirty lines in a small circular FIFO. Cache reads of a
// buffered line are answered from the buffer. Repeat writes to a buffered
// line update it in place. Buffered lines drain to memory when the cache is quiet.
//
// state       | meaning
// S_IDLE      | serve cache hits and pushes, pick a memory operation
// S_MEM_READ  | line fetch from memory for a cache read miss
// S_MEM_WRITE | oldest buffered line being written to memory
module pmem_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 16,
  parameter int LINE_W   = 128,
  parameter int OFFSET_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [ADDR_W-1:0] cache_address,
  input  logic [LINE_W-1:0] cache_wdata,
  output logic              cache_resp,
  output logic [LINE_W-1:0] cache_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam int TAG_W = ADDR_W - OFFSET_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MEM_READ  = 2'd1,
    S_MEM_WRITE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;

  logic [TAG_W-1:0]  req_tag;
  logic              full;
  logic              skip_head;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;

  logic rd_hit, rd_fill, coal, push, pop, load_rd, load_wr;

  // The byte offset inside the line never matters; lines are matched by tag.
  logic unused_offset;
  assign unused_offset = ^cache_address[OFFSET_W-1:0];

  assign req_tag    = cache_address[ADDR_W-1:OFFSET_W];
  assign full       = (count == FULL_COUNT);
  assign skip_head  = (state == S_MEM_WRITE);
  assign pmem_read  = (state == S_MEM_READ);
  assign pmem_write = (state == S_MEM_WRITE);

  // Tag search from oldest to newest so the newest match wins; the
  // in-flight head is excluded while it is being written out.
  always_comb begin : hit_search
    logic [PTR_W-1:0] slot;
    slot    = head;
    hit     = 1'b0;
    hit_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (valid[slot] && (tag_q[slot] == req_tag) && !(skip_head && (i == 0))) begin
        hit     = 1'b1;
        hit_idx = slot;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle actions. A request seen while cache_resp is
  // high is the one just answered, so that cycle does nothing in S_IDLE.
  always_comb begin
    state_next = state;
    rd_hit     = 1'b0;
    rd_fill    = 1'b0;
    coal       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    load_rd    = 1'b0;
    load_wr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cache_resp) begin
          if (cache_read) begin
            if (hit) begin
              rd_hit = 1'b1;
            end else begin
              load_rd    = 1'b1;
              state_next = S_MEM_READ;
            end
          end else if (cache_write) begin
            if (hit) begin
              coal = 1'b1;
            end else if (!full) begin
              push = 1'b1;
            end else begin
              load_wr    = 1'b1;
              state_next = S_MEM_WRITE;
            end
          end else if (count != '0) begin
            load_wr    = 1'b1;
            state_next = S_MEM_WRITE;
          end
        end
      end
      S_MEM_READ: begin
        if (pmem_resp) begin
          rd_fill    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_MEM_WRITE: begin
        if (pmem_resp) begin
          pop        = 1'b1;
          state_next = S_IDLE;
        end
        // A full buffer can still take a write in the cycle the head retires.
        if (!cache_resp && cache_write && !cache_read) begin
          if (hit)                     coal = 1'b1;
          else if (!full || pmem_resp) push = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pointers, occupancy, response and memory-side registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      cache_resp   <= 1'b0;
      cache_rdata  <= '0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      cache_resp <= rd_hit | rd_fill | coal | push;
      if (rd_hit)       cache_rdata <= data_q[hit_idx];
      else if (rd_fill) cache_rdata <= pmem_rdata;
      // Pop before push so a simultaneous pop/push into the same slot stays valid.
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (load_rd) pmem_address <= {req_tag, {OFFSET_W{1'b0}}};
      if (load_wr) begin
        pmem_address <= {tag_q[head], {OFFSET_W{1'b0}}};
        pmem_wdata   <= data_q[head];
      end
    end
  end

  // Entry tag/data storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail]  <= req_tag;
      data_q[tail] <= cache_wdata;
    end
    if (coal) data_q[hit_idx] <= cache_wdata;
  end

endmodule

// File: tb/tb_pmem_write_buffer.sv
// Bench for pmem_write_buffer: directed scenarios with literal expectations
// followed by randomized cache traffic against a queue/memory model.
module tb_pmem_write_buffer;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cache_read, cache_write;
  logic [15:0]  cache_address;
  logic [127:0] cache_wdata;
  logic         cache_resp;
  logic [127:0] cache_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  pmem_write_buffer dut (
    .clk(clk), .rst(rst),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_address(cache_address), .cache_wdata(cache_wdata),
    .cache_resp(cache_resp), .cache_rdata(cache_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: buffered lines oldest-first, and the memory contents.
  typedef struct packed {
    logic [11:0]  tag;
    logic [127:0] data;
  } ent_t;
  ent_t         q[$];
  logic [127:0] mem [logic [11:0]];

  function automatic logic [127:0] mem_val(input logic [11:0] t);
    if (mem.exists(t)) return mem[t];
    return {8{t, 4'hC}};
  endfunction

  function automatic int find_newest(input logic [11:0] t, input int lo);
    for (int i = q.size() - 1; i >= lo; i--)
      if (q[i].tag == t) return i;
    return -1;
  endfunction

  // Shared between driver, responder and checker.
  bit           hold = 1'b0;
  int           lat_max = 0;
  bit           op_active = 1'b0;
  bit           op_read = 1'b0;
  logic [15:0]  op_addr = '0;
  logic [127:0] op_data = '0;
  logic [15:0]  drain_addr[$];
  logic [127:0] drain_data[$];
  int           rd_count = 0;
  logic [15:0]  rd_addr_last = '0;
  logic         resp_busy = 1'b0;

  // Memory responder: answers a held request after 0..lat_max cycles unless held off.
  int wait_cnt = 0;
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
      end else if ((pmem_read || pmem_write) && !hold) begin
        if (wait_cnt == 0) begin
          pmem_resp  = 1'b1;
          pmem_rdata = pmem_read ? mem_val(pmem_address[15:4]) : {4{$urandom}};
          wait_cnt   = int'($urandom_range(0, lat_max));
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Compare process: advances the model on observed events and checks every cycle.
  bit           pend_pop = 1'b0;
  bit           prev_resp = 1'b0;
  int           c_idx, c_lo;
  logic [127:0] c_exp;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      q.delete();
      pend_pop  = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if (pend_pop) begin
        check("pop_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          mem[q[0].tag] = q[0].data;
          void'(q.pop_front());
        end
      end
      if (cache_resp) begin
        check("resp_single", prev_resp, 1'b0);
        check("resp_has_req", op_active, 1'b1);
        if (op_read) begin
          c_idx = find_newest(op_addr[15:4], 0);
          c_exp = (c_idx >= 0) ? q[c_idx].data : mem_val(op_addr[15:4]);
          check("read_data", cache_rdata, c_exp);
        end else begin
          c_lo  = pmem_write ? 1 : 0;
          c_idx = find_newest(op_addr[15:4], c_lo);
          if (c_idx >= 0) begin
            q[c_idx].data = op_data;
          end else begin
            check("push_room", q.size() < DEPTH, 1'b1);
            q.push_back('{tag: op_addr[15:4], data: op_data});
          end
        end
      end
      check("rw_exclusive", pmem_read && pmem_write, 1'b0);
      if (pmem_write) begin
        check("wr_nonempty", q.size() > 0, 1'b1);
        if (q.size() > 0) begin
          check("wr_addr", pmem_address, {q[0].tag, 4'h0});
          check("wr_data", pmem_wdata, q[0].data);
        end
      end
      if (pmem_read) begin
        check("rd_addr", pmem_address, {op_addr[15:4], 4'h0});
        check("rd_no_buffer_hit", find_newest(op_addr[15:4], 0) < 0, 1'b1);
      end
      if (pmem_read && pmem_resp) begin
        rd_count++;
        rd_addr_last = pmem_address;
      end
      pend_pop = pmem_write && pmem_resp;
      if (pend_pop) begin
        drain_addr.push_back(pmem_address);
        drain_data.push_back(pmem_wdata);
      end
      prev_resp = cache_resp;
    end
  end

  // One cache transaction, held until cache_resp, then one idle cycle.
  task automatic cache_op(input bit rd, input logic [15:0] a, input logic [127:0] d,
                          output int lat, output logic [127:0] rdata);
    op_read   = rd;
    op_addr   = a;
    op_data   = d;
    op_active = 1'b1;
    cache_read    = rd;
    cache_write   = !rd;
    cache_address = a;
    cache_wdata   = d;
    lat = 0;
    rdata = '0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cache_resp && lat < 300);
    check("resp_timeout", cache_resp, 1'b1);
    resp_busy = pmem_read | pmem_write;
    rdata     = cache_rdata;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    @(negedge clk);
    op_active = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || pmem_write || pmem_read) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_done", (q.size() == 0) && !pmem_write, 1'b1);
  endtask

  task automatic clear_log();
    drain_addr.delete();
    drain_data.delete();
  endtask

  function automatic logic [15:0] log_addr(input int i);
    if (i < drain_addr.size()) return drain_addr[i];
    return 16'hxxxx;
  endfunction

  function automatic logic [127:0] log_data(input int i);
    if (i < drain_data.size()) return drain_data[i];
    return 'x;
  endfunction

  localparam logic [127:0] D1 = 128'h1111_0000_1111_0000_1111_0000_1111_0001;
  localparam logic [127:0] D2 = 128'h2222_0000_2222_0000_2222_0000_2222_0002;
  localparam logic [127:0] D3 = 128'h3333_0000_3333_0000_3333_0000_3333_0003;
  localparam logic [127:0] D4 = 128'h4444_0000_4444_0000_4444_0000_4444_0004;
  localparam logic [127:0] D5 = 128'h5555_0000_5555_0000_5555_0000_5555_0005;
  localparam logic [127:0] R1 = 128'hABCD_EF01_2345_6789_ABCD_EF01_2345_6789;
  localparam logic [127:0] TD = 128'hDEAD_BEEF_0000_1234_DEAD_BEEF_0000_1234;

  int           lat, rdc;
  logic [127:0] rdata;

  initial begin
    rst = 1'b1;
    cache_read = 1'b0;
    cache_write = 1'b0;
    cache_address = '0;
    cache_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cache_resp", cache_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write absorbed in one cycle, then drained.
    hold = 1'b1;
    cache_op(1'b0, 16'h1230, D1, lat, rdata);
    check("t2_lat", lat, 1);
    check("t2_no_pmem_at_resp", resp_busy, 1'b0);
    repeat (2) @(negedge clk);
    check("t2_pmem_write", pmem_write, 1'b1);
    check("t2_addr", pmem_address, 16'h1230);
    check("t2_wdata", pmem_wdata, D1);
    clear_log();
    hold = 1'b0;
    wait_idle(50);
    check("t2_drain_cnt", drain_addr.size(), 1);
    check("t2_drain_addr", log_addr(0), 16'h1230);

    // Read of a buffered line is forwarded.
    hold = 1'b1;
    rdc = rd_count;
    cache_op(1'b0, 16'h1230, TD, lat, rdata);
    cache_op(1'b1, 16'h1238, '0, lat, rdata);
    check("t3_lat", lat, 1);
    check("t3_rdata", rdata, TD);
    check("t3_no_pmem_read", rd_count, rdc);
    hold = 1'b0;
    wait_idle(50);

    // Read miss fetched from memory.
    mem[12'h800] = R1;
    rdc = rd_count;
    cache_op(1'b1, 16'h8004, '0, lat, rdata);
    check("t4_rdata", rdata, R1);
    check("t4_reads", rd_count, rdc + 1);
    check("t4_addr", rd_addr_last, 16'h8000);

    // Full buffer stalls the fifth write until a slot frees.
    hold = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      cache_op(1'b0, 16'(i * 16), {4{32'hA000_0000 | 32'(i)}}, lat, rdata);
      check("t5_lat", lat, 1);
    end
    fork
      begin
        repeat (8) @(negedge clk);
        hold = 1'b0;
      end
    join_none
    cache_op(1'b0, 16'h0040, {4{32'hA000_0004}}, lat, rdata);
    check("t5_stalled", lat > 8, 1'b1);
    wait_idle(100);
    check("t5_drain_cnt", drain_addr.size(), 5);
    for (int i = 0; i < 5; i++) check("t5_drain_order", log_addr(i), 16'(i * 16));

    // Coalescing skips the in-flight head.
    hold = 1'b1;
    clear_log();
    cache_op(1'b0, 16'h4000, D1, lat, rdata);
    repeat (2) @(negedge clk);
    check("t6_head_inflight", pmem_address, 16'h4000);
    cache_op(1'b0, 16'h5000, D2, lat, rdata);
    cache_op(1'b0, 16'h5000, D3, lat, rdata);
    cache_op(1'b0, 16'h4000, D4, lat, rdata);
    hold = 1'b0;
    wait_idle(100);
    check("t6_drain_cnt", drain_addr.size(), 3);
    check("t6_a0", log_addr(0), 16'h4000);
    check("t6_d0", log_data(0), D1);
    check("t6_a1", log_addr(1), 16'h5000);
    check("t6_d1", log_data(1), D3);
    check("t6_a2", log_addr(2), 16'h4000);
    check("t6_d2", log_data(2), D4);

    // Reset in the middle of a drain abandons the buffered line.
    hold = 1'b1;
    clear_log();
    cache_op(1'b0, 16'h7770, D5, lat, rdata);
    repeat (2) @(negedge clk);
    check("t1_draining", pmem_write, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t1_cache_resp", cache_resp, 1'b0);
    check("t1_cache_rdata", cache_rdata, 128'h0);
    check("t1_pmem_read", pmem_read, 1'b0);
    check("t1_pmem_write", pmem_write, 1'b0);
    check("t1_pmem_address", pmem_address, 16'h0);
    check("t1_pmem_wdata", pmem_wdata, 128'h0);
    rst = 1'b0;
    hold = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_no_drain", pmem_write, 1'b0);
    check("t1_log_empty", drain_addr.size(), 0);
    rdc = rd_count;
    cache_op(1'b1, 16'h7770, '0, lat, rdata);
    check("t1_rdata", rdata, {8{16'h777C}});
    check("t1_went_to_pmem", rd_count, rdc + 1);

    // Randomized traffic over a small tag set so hits, fills and stalls occur.
    lat_max = 3;
    for (int n = 0; n < 400; n++) begin
      logic [11:0] t;
      if (n % 50 == 0) lat_max = int'($urandom_range(0, 6));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      t = 12'h100 + 12'($urandom_range(0, 5));
      cache_op($urandom_range(0, 9) < 4, {t, 4'($urandom)},
               {$urandom, $urandom, $urandom, $urandom}, lat, rdata);
    end
    wait_idle(500);
    for (int i = 0; i < 6; i++) cache_op(1'b1, {12'h100 + 12'(i), 4'h0}, '0, lat, rdata);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
